// File: rtl/semaforo_pkg.sv
// Shared light codes, FSM state codes and default timing for the intersection controller.
// The pedestrian-signal block imports the same light codes from here.
package semaforo_pkg;

  typedef enum logic [1:0] {
    ROJO     = 2'b00,
    AMARILLO = 2'b01,
    VERDE    = 2'b10
  } luz_t;

  typedef enum logic [2:0] {
    B_VERDE    = 3'd0,
    B_AMARILLO = 3'd1,
    ROJO_BA    = 3'd2,
    A_VERDE    = 3'd3,
    A_AMARILLO = 3'd4,
    ROJO_AB    = 3'd5
  } estado_t;

  localparam int unsigned T_VERDE_DEF     = 8;
  localparam int unsigned T_AMARILLO_DEF  = 2;
  localparam int unsigned T_TODO_ROJO_DEF = 1;
  localparam int unsigned T_VERDE_MIN_DEF = 3;
  localparam int unsigned CNT_W_DEF       = 4;

  // Fixed rotation; codes 6/7 fall back to B_VERDE.
  function automatic estado_t siguiente(input estado_t e);
    case (e)
      B_VERDE:    return B_AMARILLO;
      B_AMARILLO: return ROJO_BA;
      ROJO_BA:    return A_VERDE;
      A_VERDE:    return A_AMARILLO;
      A_AMARILLO: return ROJO_AB;
      default:    return B_VERDE;
    endcase
  endfunction

  // Returns {Semaforo_A, Semaforo_B}; never two non-red lights at once.
  function automatic logic [3:0] luces(input estado_t e);
    case (e)
      B_VERDE:    return {ROJO, VERDE};
      B_AMARILLO: return {ROJO, AMARILLO};
      A_VERDE:    return {VERDE, ROJO};
      A_AMARILLO: return {AMARILLO, ROJO};
      default:    return {ROJO, ROJO};
    endcase
  endfunction

endpackage

// File: rtl/controlador_semaforos_if.sv
// Control and status bundle of the traffic-light controller.
// master = stimulus/consumer side, slave = controller side.
interface controlador_semaforos_if;

  logic       ENB;
  logic       Peaton_A;
  logic       Peaton_B;
  logic [1:0] Semaforo_A;
  logic [1:0] Semaforo_B;
  logic       Pend_A;
  logic       Pend_B;
  logic [2:0] Estado;

  modport master (
    output ENB,
    output Peaton_A,
    output Peaton_B,
    input  Semaforo_A,
    input  Semaforo_B,
    input  Pend_A,
    input  Pend_B,
    input  Estado
  );

  modport slave (
    input  ENB,
    input  Peaton_A,
    input  Peaton_B,
    output Semaforo_A,
    output Semaforo_B,
    output Pend_A,
    output Pend_B,
    output Estado
  );

endinterface

// File: rtl/temporizador_estado.sv
// Per-state timer: loadable up counter with enable and a terminal-count flag
// against a caller-supplied limit.
module temporizador_estado #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cargar_i,
  input  logic [CNT_W-1:0] valor_i,
  input  logic [CNT_W-1:0] limite_i,
  output logic [CNT_W-1:0] cuenta_o,
  output logic             fin_o
);

  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (en_i) begin
      if (cargar_i) begin
        cuenta_d = valor_i;
      end else begin
        cuenta_d = cuenta_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta_o = cuenta_q;
  assign fin_o    = (cuenta_q == limite_i);

endmodule

// File: rtl/controlador_semaforos.sv
// Two-way intersection light controller: timed six-state FSM with all-red clearance
// and latched pedestrian requests that may cut a green short after a minimum time.
module controlador_semaforos
  import semaforo_pkg::*;
#(
  parameter int unsigned T_VERDE     = T_VERDE_DEF,
  parameter int unsigned T_AMARILLO  = T_AMARILLO_DEF,
  parameter int unsigned T_TODO_ROJO = T_TODO_ROJO_DEF,
  parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  controlador_semaforos_if.slave   bus
);

  estado_t          estado_q, estado_d;
  logic             pend_a_q, pend_a_d;
  logic             pend_b_q, pend_b_d;
  logic [1:0]       sem_a_q, sem_a_d;
  logic [1:0]       sem_b_q, sem_b_d;

  logic [CNT_W-1:0] cuenta;
  logic [CNT_W-1:0] limite;
  logic             fin;
  logic             ilegal;
  logic             peticion;
  logic             minimo_ok;
  logic             avanzar;
  logic             cargar;

  temporizador_estado #(
    .CNT_W (CNT_W)
  ) u_temporizador (
    .clk_i    (CLK),
    .rst_i    (RST),
    .en_i     (bus.ENB),
    .cargar_i (cargar),
    .valor_i  ('0),
    .limite_i (limite),
    .cuenta_o (cuenta),
    .fin_o    (fin)
  );

  always_comb begin
    limite = CNT_W'(T_VERDE - 1);
    case (estado_q)
      B_AMARILLO, A_AMARILLO: limite = CNT_W'(T_AMARILLO - 1);
      ROJO_BA, ROJO_AB:       limite = CNT_W'(T_TODO_ROJO - 1);
      default:                limite = CNT_W'(T_VERDE - 1);
    endcase
  end

  // A live request counts even before it is latched, so a request on the
  // last eligible edge still shortens the green.
  always_comb begin
    ilegal    = (estado_q > ROJO_AB);
    minimo_ok = (cuenta >= CNT_W'(T_VERDE_MIN - 1));
    peticion  = ((estado_q == A_VERDE) && (pend_a_q || bus.Peaton_A)) ||
                ((estado_q == B_VERDE) && (pend_b_q || bus.Peaton_B));
    avanzar   = fin || (peticion && minimo_ok);
    cargar    = ilegal || avanzar;
  end

  always_comb begin
    estado_d = estado_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    if (bus.ENB) begin
      if (ilegal) begin
        estado_d = B_VERDE;
      end else if (avanzar) begin
        estado_d = siguiente(estado_q);
      end
      // Leaving the green clears the request even if it is re-asserted now.
      if (estado_q == A_VERDE) begin
        pend_a_d = avanzar ? 1'b0 : (pend_a_q | bus.Peaton_A);
      end
      if (estado_q == B_VERDE) begin
        pend_b_d = avanzar ? 1'b0 : (pend_b_q | bus.Peaton_B);
      end
    end
    {sem_a_d, sem_b_d} = luces(estado_d);
  end

  // Lights are registered from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado_q <= B_VERDE;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      sem_a_q  <= ROJO;
      sem_b_q  <= VERDE;
    end else begin
      estado_q <= estado_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      sem_a_q  <= sem_a_d;
      sem_b_q  <= sem_b_d;
    end
  end

  assign bus.Semaforo_A = sem_a_q;
  assign bus.Semaforo_B = sem_b_q;
  assign bus.Pend_A     = pend_a_q;
  assign bus.Pend_B     = pend_b_q;
  assign bus.Estado     = estado_q;

  a_seguridad: assert property (@(posedge CLK) disable iff (RST)
    !((sem_a_q != ROJO) && (sem_b_q != ROJO)));

endmodule

// File: tb/tb_controlador_semaforos.sv
// Self-checking bench for controlador_semaforos: per-scenario tasks and a cycle
// model feeding an expected-value queue compared against the DUT after each edge.
module tb_controlador_semaforos;

  localparam int TV   = 8;
  localparam int TA   = 2;
  localparam int TR   = 1;
  localparam int TMIN = 3;

  logic CLK = 1'b0;
  logic RST;

  controlador_semaforos_if bus ();

  controlador_semaforos u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  logic [8:0] esperado;

  int m_est;
  int m_tim;
  bit m_pa;
  bit m_pb;

  function automatic logic [3:0] luces_mod(input int e);
    case (e)
      0:       return 4'b0010;
      1:       return 4'b0001;
      3:       return 4'b1000;
      4:       return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int dur(input int e);
    if (e == 0 || e == 3) return TV;
    if (e == 1 || e == 4) return TA;
    return TR;
  endfunction

  // Expected state for cycle k after reset with no requests.
  function automatic int est_tabla(input int k);
    int r;
    r = k % 22;
    if (r < 8)  return 0;
    if (r < 10) return 1;
    if (r < 11) return 2;
    if (r < 19) return 3;
    if (r < 21) return 4;
    return 5;
  endfunction

  function automatic logic [8:0] obs();
    return {bus.Semaforo_A, bus.Semaforo_B, bus.Pend_A, bus.Pend_B, bus.Estado};
  endfunction

  task automatic paso(input bit enb, input bit pa, input bit pb);
    int  d;
    bit  req;
    bit  adv;
    bus.ENB      = enb;
    bus.Peaton_A = pa;
    bus.Peaton_B = pb;
    if (enb) begin
      d   = dur(m_est);
      req = (m_est == 3 && (m_pa || pa)) || (m_est == 0 && (m_pb || pb));
      adv = (m_tim == d - 1) || (req && m_tim >= TMIN - 1);
      if (m_est == 3) m_pa = adv ? 1'b0 : (m_pa | pa);
      if (m_est == 0) m_pb = adv ? 1'b0 : (m_pb | pb);
      if (adv) begin
        m_est = (m_est + 1) % 6;
        m_tim = 0;
      end else begin
        m_tim++;
      end
    end
    sb.push_back({luces_mod(m_est), m_pa, m_pb, 3'(m_est)});
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must react at once.
  task automatic reset_medio(input string nombre);
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'b0010_00_000) begin
      errors++;
      $display("FAIL %s reset inmediato: got %b want %b", nombre, obs(), 9'b0010_00_000);
    end
    m_est = 0;
    m_tim = 0;
    m_pa  = 1'b0;
    m_pb  = 1'b0;
    sb.delete();
    bus.ENB      = 1'b1;
    bus.Peaton_A = 1'b0;
    bus.Peaton_B = 1'b0;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST          = 1'b1;
    bus.ENB      = 1'b0;
    bus.Peaton_A = 1'b0;
    bus.Peaton_B = 1'b0;
    m_est = 0; m_tim = 0; m_pa = 1'b0; m_pb = 1'b0;
    #2;
    checks++;
    if (obs() !== 9'b0010_00_000) begin
      errors++;
      $display("FAIL reset_inicial: got %b want %b", obs(), 9'b0010_00_000);
    end
    #2;
    RST = 1'b0;
    for (int i = 0; i < 11; i++) begin
      paso(1'b1, 1'b0, 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado) begin
        errors++;
        $display("FAIL reset_arranque ciclo %0d: got %b want %b", i + 1, obs(), esperado);
      end
    end
    checks++;
    if (bus.Estado !== 3'd3) begin
      errors++;
      $display("FAIL reset_llega_a_verde: got %0d want 3", bus.Estado);
    end
    reset_medio("reset_en_a_verde");
    for (int i = 0; i < 44; i++) begin
      paso(1'b1, 1'b0, 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado || int'(bus.Estado) != est_tabla(i + 1)) begin
        errors++;
        $display("FAIL reset_periodo ciclo %0d: got %b want %b (estado tabla %0d)",
                 i + 1, obs(), esperado, est_tabla(i + 1));
      end
    end
  endtask

  task automatic test_congelado();
    int  cnt;
    bit  fuera;
    reset_medio("congelado");
    for (int i = 0; i < 11; i++) begin
      paso(1'b1, 1'b0, 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado) begin
        errors++;
        $display("FAIL congelado_previo ciclo %0d: got %b want %b", i, obs(), esperado);
      end
    end
    cnt   = 1;
    fuera = 1'b0;
    for (int i = 0; i < 20 && !fuera; i++) begin
      paso((cnt >= 4 && cnt < 9) ? 1'b0 : 1'b1, (cnt == 6), 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado) begin
        errors++;
        $display("FAIL congelado ciclo %0d: got %b want %b", cnt, obs(), esperado);
      end
      if (cnt == 7) begin
        checks++;
        if (bus.Pend_A !== 1'b0 || bus.Semaforo_A !== 2'b10) begin
          errors++;
          $display("FAIL congelado_peaton: got pend=%b A=%b want pend=0 A=10",
                   bus.Pend_A, bus.Semaforo_A);
        end
      end
      if (bus.Estado == 3'd3) cnt++;
      else fuera = 1'b1;
    end
    checks++;
    if (cnt != 13) begin
      errors++;
      $display("FAIL congelado_duracion: got %0d want 13", cnt);
    end
  endtask

  task automatic test_pedido_temprano();
    int est_esp[3] = '{0, 0, 1};
    bit pb_esp[3]  = '{1, 1, 0};
    reset_medio("pedido_temprano");
    for (int i = 0; i < 3; i++) begin
      paso(1'b1, 1'b0, (i == 0));
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado || int'(bus.Estado) != est_esp[i] || bus.Pend_B !== pb_esp[i]) begin
        errors++;
        $display("FAIL pedido_temprano ciclo %0d: got %b want %b (estado %0d pend_b %b)",
                 i + 1, obs(), esperado, est_esp[i], pb_esp[i]);
      end
    end
  endtask

  task automatic test_pedido_tardio();
    int est_esp[9] = '{0, 0, 0, 0, 0, 1, 1, 2, 3};
    reset_medio("pedido_tardio");
    for (int i = 0; i < 9; i++) begin
      paso(1'b1, 1'b0, (i == 5));
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado || int'(bus.Estado) != est_esp[i]) begin
        errors++;
        $display("FAIL pedido_tardio ciclo %0d: got %b want %b (estado %0d)",
                 i + 1, obs(), esperado, est_esp[i]);
      end
    end
  endtask

  task automatic test_peaton_a();
    int est_esp[3] = '{3, 3, 4};
    bit pa_esp[3]  = '{1, 1, 0};
    reset_medio("peaton_a");
    for (int i = 0; i < 11; i++) begin
      paso(1'b1, 1'b1, 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado || (i < 10 && bus.Pend_A !== 1'b0)) begin
        errors++;
        $display("FAIL peaton_a_ignorado ciclo %0d: got %b want %b", i + 1, obs(), esperado);
      end
    end
    for (int i = 0; i < 3; i++) begin
      paso(1'b1, 1'b1, 1'b0);
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado || int'(bus.Estado) != est_esp[i] || bus.Pend_A !== pa_esp[i]) begin
        errors++;
        $display("FAIL peaton_a_verde ciclo %0d: got %b want %b (estado %0d pend_a %b)",
                 i, obs(), esperado, est_esp[i], pa_esp[i]);
      end
    end
  endtask

  task automatic test_aleatorio();
    int  previo;
    int  racha;
    bit  enb;
    reset_medio("aleatorio");
    racha = 0;
    for (int i = 0; i < 2000; i++) begin
      previo = int'(bus.Estado);
      enb    = ($urandom_range(0, 9) < 8);
      paso(enb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      esperado = sb.pop_front();
      checks++;
      if (obs() !== esperado) begin
        errors++;
        $display("FAIL aleatorio ciclo %0d: got %b want %b", i, obs(), esperado);
      end
      checks++;
      if (bus.Semaforo_A !== 2'b00 && bus.Semaforo_B !== 2'b00) begin
        errors++;
        $display("FAIL seguridad ciclo %0d: got A=%b B=%b want one of them 00",
                 i, bus.Semaforo_A, bus.Semaforo_B);
      end
      if (enb) racha++;
      if (int'(bus.Estado) != previo) begin
        checks++;
        if (((previo == 1 || previo == 4) && racha != TA) ||
            ((previo == 2 || previo == 5) && racha != TR) ||
            ((previo == 0 || previo == 3) && (racha < TMIN || racha > TV))) begin
          errors++;
          $display("FAIL duracion estado %0d ciclo %0d: got %0d enabled cycles", previo, i, racha);
        end
        racha = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_congelado();
    test_pedido_temprano();
    test_pedido_tardio();
    test_peaton_a();
    test_aleatorio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
